// File: rtl/stream_seq_checker.sv
// Stream sink that checks received words form a gapless incrementing sequence.
// Optionally throttles ready_o with an LFSR to exercise upstream FIFO corners.
// Counts accepted beats and mismatches, and captures the first mismatch.
module stream_seq_checker #(
   parameter int unsigned           DATA_WIDTH  = 32,
   parameter int unsigned           CNT_WIDTH   = 32,
   parameter logic [DATA_WIDTH-1:0] START_VALUE = '0,
   parameter logic [15:0]           LFSR_SEED   = 16'hACE1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic [CNT_WIDTH-1:0]  target_i,
   input  logic                  stall_en_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [CNT_WIDTH-1:0]  beat_cnt_o,
   output logic [CNT_WIDTH-1:0]  err_cnt_o,
   output logic                  err_o,
   output logic [CNT_WIDTH-1:0]  first_err_idx_o,
   output logic [DATA_WIDTH-1:0] first_err_data_o
);

   localparam logic [CNT_WIDTH-1:0]  CntMax  = '1;
   localparam logic [CNT_WIDTH-1:0]  CntOne  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [DATA_WIDTH-1:0] DataOne = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
   // Galois feedback mask for x^16 + x^14 + x^13 + x^11 (right-shifting form)
   localparam logic [15:0]           LfsrTaps = 16'hB400;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e                state_q;
   logic [15:0]           lfsr_q;
   logic [15:0]           lfsr_d;
   logic [DATA_WIDTH-1:0] expected_q;
   logic [CNT_WIDTH-1:0]  target_q;
   logic [CNT_WIDTH-1:0]  beat_cnt_q;
   logic [CNT_WIDTH-1:0]  err_cnt_q;
   logic [CNT_WIDTH-1:0]  first_err_idx_q;
   logic [DATA_WIDTH-1:0] first_err_data_q;
   logic                  err_q;
   logic                  accept;

   // Next LFSR value; only committed while running
   always_comb begin
      lfsr_d = {1'b0, lfsr_q[15:1]};
      if (lfsr_q[0]) begin
         lfsr_d = lfsr_d ^ LfsrTaps;
      end
   end

   // Ready is a function of registered state and stall enable only, never of valid_i
   assign ready_o = (state_q == StRun) && (!stall_en_i || lfsr_q[0]);
   assign accept  = valid_i && ready_o;

   assign busy_o           = (state_q == StRun);
   assign done_o           = (state_q == StDone);
   assign beat_cnt_o       = beat_cnt_q;
   assign err_cnt_o        = err_cnt_q;
   assign err_o            = err_q;
   assign first_err_idx_o  = first_err_idx_q;
   assign first_err_data_o = first_err_data_q;

   // Control FSM together with all result and checking state
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q          <= StIdle;
         lfsr_q           <= LFSR_SEED;
         expected_q       <= START_VALUE;
         target_q         <= '0;
         beat_cnt_q       <= '0;
         err_cnt_q        <= '0;
         first_err_idx_q  <= '0;
         first_err_data_q <= '0;
         err_q            <= 1'b0;
      end else begin
         case (state_q)
            StIdle, StDone: begin
               if (start_i) begin
                  target_q         <= target_i;
                  expected_q       <= START_VALUE;
                  beat_cnt_q       <= '0;
                  err_cnt_q        <= '0;
                  first_err_idx_q  <= '0;
                  first_err_data_q <= '0;
                  err_q            <= 1'b0;
                  state_q          <= (target_i == '0) ? StDone : StRun;
               end
            end
            StRun: begin
               lfsr_q <= lfsr_d;
               if (accept) begin
                  // Expected tracks the beat index; no resync to received data
                  expected_q <= expected_q + DataOne;
                  if (beat_cnt_q != CntMax) begin
                     beat_cnt_q <= beat_cnt_q + CntOne;
                  end
                  if (data_i != expected_q) begin
                     if (err_cnt_q != CntMax) begin
                        err_cnt_q <= err_cnt_q + CntOne;
                     end
                     if (!err_q) begin
                        first_err_idx_q  <= beat_cnt_q;
                        first_err_data_q <= data_i;
                        err_q            <= 1'b1;
                     end
                  end
                  // target_q is nonzero in RUN, so target_q - 1 cannot underflow
                  if (beat_cnt_q == target_q - CntOne) begin
                     state_q <= StDone;
                  end
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stream_seq_checker.sv
// Directed bench for stream_seq_checker: one task per scenario, inline checks.
module tb_stream_seq_checker;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] target = '0;
   logic        stall_en = 1'b0;
   logic [31:0] data = '0;
   logic        valid = 1'b0;
   logic        ready, busy, done, err;
   logic [31:0] beat_cnt, err_cnt, first_err_idx, first_err_data;

   // Second instance starts near the top of the data range to exercise wrap
   logic        w_start = 1'b0;
   logic [31:0] w_target = '0;
   logic        w_stall_en = 1'b0;
   logic [31:0] w_data = '0;
   logic        w_valid = 1'b0;
   logic        w_ready, w_busy, w_done, w_err;
   logic [31:0] w_beat_cnt, w_err_cnt, w_first_err_idx, w_first_err_data;

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] seq [0:1023];

   always #5 clk = ~clk;

   stream_seq_checker #(
      .DATA_WIDTH (32),
      .CNT_WIDTH  (32),
      .START_VALUE(32'd0),
      .LFSR_SEED  (16'hACE1)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .start_i         (start),
      .target_i        (target),
      .stall_en_i      (stall_en),
      .data_i          (data),
      .valid_i         (valid),
      .ready_o         (ready),
      .busy_o          (busy),
      .done_o          (done),
      .beat_cnt_o      (beat_cnt),
      .err_cnt_o       (err_cnt),
      .err_o           (err),
      .first_err_idx_o (first_err_idx),
      .first_err_data_o(first_err_data)
   );

   stream_seq_checker #(
      .DATA_WIDTH (32),
      .CNT_WIDTH  (32),
      .START_VALUE(32'hFFFF_FFFE),
      .LFSR_SEED  (16'hACE1)
   ) dut_w (
      .clk_i           (clk),
      .rst_i           (rst),
      .start_i         (w_start),
      .target_i        (w_target),
      .stall_en_i      (w_stall_en),
      .data_i          (w_data),
      .valid_i         (w_valid),
      .ready_o         (w_ready),
      .busy_o          (w_busy),
      .done_o          (w_done),
      .beat_cnt_o      (w_beat_cnt),
      .err_cnt_o       (w_err_cnt),
      .err_o           (w_err),
      .first_err_idx_o (w_first_err_idx),
      .first_err_data_o(w_first_err_data)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Starts a run and sources seq[0..n_words-1], holding data while not accepted.
   // Tracks its own beat count and flags any cycle where beat_cnt disagrees.
   task automatic run_stream(input int unsigned tgt, input int unsigned n_words,
                             input bit stall, input bit gaps,
                             output int cycles, output int ready_low, output int cnt_bad,
                             output bit timed_out, output bit first_busy,
                             output bit first_ready);
      int unsigned idx;
      int unsigned model_cnt;
      bit          acc;
      idx = 0; model_cnt = 0; cycles = 0; ready_low = 0; cnt_bad = 0; timed_out = 0;
      target = tgt; stall_en = stall; start = 1'b1; valid = 1'b0; data = 32'hDEAD_BEEF;
      tick();
      start = 1'b0;
      first_busy = busy;
      first_ready = ready;
      valid = (idx < n_words) && (!gaps || ($urandom_range(0, 3) != 0));
      data = valid ? seq[idx] : 32'hDEAD_BEEF;
      while (!done && !timed_out) begin
         if (cycles >= 20000) begin
            timed_out = 1'b1;
         end else begin
            if (!ready) ready_low++;
            acc = ready && valid;
            tick();
            cycles++;
            if (acc) begin
               idx++;
               model_cnt++;
            end
            if (beat_cnt !== model_cnt) cnt_bad++;
            valid = (idx < n_words) && (!gaps || ($urandom_range(0, 3) != 0));
            data = valid ? seq[idx] : 32'hDEAD_BEEF;
         end
      end
      valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      n_vec++;
      if ({ready, busy, done, err} !== 4'b0000) begin
         n_err++; $display("FAIL reset_flags got %b want 0000", {ready, busy, done, err});
      end
      n_vec++;
      if ({beat_cnt, err_cnt, first_err_idx, first_err_data} !== 128'd0) begin
         n_err++; $display("FAIL reset_counters got %h/%h/%h/%h want 0", beat_cnt, err_cnt,
                           first_err_idx, first_err_data);
      end
      n_vec++;
      if ({w_ready, w_busy, w_done, w_err} !== 4'b0000) begin
         n_err++; $display("FAIL reset_wrap_flags got %b want 0000",
                           {w_ready, w_busy, w_done, w_err});
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_target_zero();
      bit saw_ready;
      target = 32'd0; stall_en = 1'b0; valid = 1'b1; data = 32'd0; start = 1'b1;
      saw_ready = ready;
      tick();
      start = 1'b0;
      n_vec++;
      if ({done, busy, ready} !== 3'b100) begin
         n_err++; $display("FAIL zero_done got done/busy/ready=%b want 100", {done, busy, ready});
      end
      for (int i = 0; i < 4; i++) begin
         saw_ready = saw_ready | ready;
         tick();
      end
      n_vec++;
      if (saw_ready !== 1'b0) begin
         n_err++; $display("FAIL zero_ready_seen got %b want 0", saw_ready);
      end
      n_vec++;
      if (beat_cnt !== 32'd0) begin
         n_err++; $display("FAIL zero_beats got %0d want 0", beat_cnt);
      end
      valid = 1'b0;
   endtask

   task automatic test_clean_run();
      int cyc, rl, cb;
      bit to, fb, fr;
      for (int i = 0; i < 16; i++) seq[i] = i;
      run_stream(16, 16, 1'b0, 1'b0, cyc, rl, cb, to, fb, fr);
      n_vec++;
      if ({fb, fr} !== 2'b11) begin
         n_err++; $display("FAIL clean_first_cycle got busy/ready=%b want 11", {fb, fr});
      end
      // 16 edges after the start edge, i.e. done visible in cycle start+17
      n_vec++;
      if (cyc !== 16 || to) begin
         n_err++; $display("FAIL clean_latency got %0d edges want 16", cyc);
      end
      n_vec++;
      if (beat_cnt !== 32'd16 || done !== 1'b1 || ready !== 1'b0) begin
         n_err++; $display("FAIL clean_end got beats=%0d done=%b ready=%b want 16 1 0",
                           beat_cnt, done, ready);
      end
      n_vec++;
      if (err_cnt !== 32'd0 || err !== 1'b0 || cb !== 0) begin
         n_err++; $display("FAIL clean_errors got err_cnt=%0d err=%b cnt_bad=%0d want 0 0 0",
                           err_cnt, err, cb);
      end
   endtask

   task automatic test_single_error();
      int cyc, rl, cb;
      bit to, fb, fr;
      seq[0] = 0; seq[1] = 1; seq[2] = 2; seq[3] = 7; seq[4] = 4; seq[5] = 5;
      run_stream(6, 6, 1'b0, 1'b0, cyc, rl, cb, to, fb, fr);
      n_vec++;
      if (err_cnt !== 32'd1 || err !== 1'b1 || beat_cnt !== 32'd6) begin
         n_err++; $display("FAIL single_err got err_cnt=%0d err=%b beats=%0d want 1 1 6",
                           err_cnt, err, beat_cnt);
      end
      n_vec++;
      if (first_err_idx !== 32'd3 || first_err_data !== 32'd7) begin
         n_err++; $display("FAIL single_capture got idx=%0d data=%0d want 3 7",
                           first_err_idx, first_err_data);
      end
   endtask

   task automatic test_second_error();
      int cyc, rl, cb;
      bit to, fb, fr;
      seq[0] = 0; seq[1] = 1; seq[2] = 2; seq[3] = 7; seq[4] = 4; seq[5] = 9;
      run_stream(6, 6, 1'b0, 1'b0, cyc, rl, cb, to, fb, fr);
      n_vec++;
      if (err_cnt !== 32'd2 || beat_cnt !== 32'd6) begin
         n_err++; $display("FAIL second_err got err_cnt=%0d beats=%0d want 2 6",
                           err_cnt, beat_cnt);
      end
      n_vec++;
      if (first_err_idx !== 32'd3 || first_err_data !== 32'd7) begin
         n_err++; $display("FAIL second_capture got idx=%0d data=%0d want 3 7",
                           first_err_idx, first_err_data);
      end
   endtask

   task automatic test_restart();
      target = 32'd4; stall_en = 1'b0; valid = 1'b1; data = 32'd0; start = 1'b1;
      tick();
      start = 1'b0;
      n_vec++;
      if ({err, busy} !== 2'b01 || err_cnt !== 32'd0 || beat_cnt !== 32'd0) begin
         n_err++; $display("FAIL restart_clear got err=%b busy=%b err_cnt=%0d beats=%0d",
                           err, busy, err_cnt, beat_cnt);
      end
      n_vec++;
      if (first_err_idx !== 32'd0 || first_err_data !== 32'd0) begin
         n_err++; $display("FAIL restart_capture got idx=%0d data=%0d want 0 0",
                           first_err_idx, first_err_data);
      end
      for (int k = 0; k < 4; k++) begin
         data = k;
         tick();
      end
      valid = 1'b0;
      n_vec++;
      if (done !== 1'b1 || beat_cnt !== 32'd4 || err_cnt !== 32'd0) begin
         n_err++; $display("FAIL restart_run got done=%b beats=%0d err_cnt=%0d want 1 4 0",
                           done, beat_cnt, err_cnt);
      end
   endtask

   task automatic test_start_ignored();
      target = 32'd8; stall_en = 1'b0; valid = 1'b1; data = 32'd0; start = 1'b1;
      tick();
      for (int k = 0; k < 8; k++) begin
         data = k;
         start = (k == 3);
         target = (k == 3) ? 32'd2 : 32'd8;
         tick();
         if (k == 3) begin
            n_vec++;
            if (beat_cnt !== 32'd4 || busy !== 1'b1) begin
               n_err++; $display("FAIL ignore_mid got beats=%0d busy=%b want 4 1",
                                 beat_cnt, busy);
            end
         end
      end
      start = 1'b0; valid = 1'b0;
      n_vec++;
      if (done !== 1'b1 || beat_cnt !== 32'd8 || err_cnt !== 32'd0) begin
         n_err++; $display("FAIL ignore_end got done=%b beats=%0d err_cnt=%0d want 1 8 0",
                           done, beat_cnt, err_cnt);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] wv [4];
      wv[0] = 32'hFFFF_FFFE; wv[1] = 32'hFFFF_FFFF; wv[2] = 32'h0; wv[3] = 32'h1;
      w_target = 32'd4; w_valid = 1'b1; w_data = wv[0]; w_start = 1'b1;
      tick();
      w_start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         w_data = wv[k];
         tick();
      end
      w_valid = 1'b0;
      n_vec++;
      if (w_done !== 1'b1 || w_beat_cnt !== 32'd4 || w_err_cnt !== 32'd0) begin
         n_err++; $display("FAIL wrap got done=%b beats=%0d err_cnt=%0d want 1 4 0",
                           w_done, w_beat_cnt, w_err_cnt);
      end
   endtask

   task automatic test_reset_mid_run();
      int cyc, rl, cb;
      bit to, fb, fr;
      target = 32'd10; stall_en = 1'b0; valid = 1'b1; data = 32'd0; start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 5; k++) begin
         data = (k == 2) ? 32'd99 : k;
         tick();
      end
      n_vec++;
      if (beat_cnt !== 32'd5 || err_cnt !== 32'd1 || first_err_data !== 32'd99) begin
         n_err++; $display("FAIL midrst_before got beats=%0d err_cnt=%0d data=%0d want 5 1 99",
                           beat_cnt, err_cnt, first_err_data);
      end
      data = 32'd5; rst = 1'b1;
      tick();
      rst = 1'b0; valid = 1'b0;
      n_vec++;
      if ({ready, busy, done, err} !== 4'b0000) begin
         n_err++; $display("FAIL midrst_flags got %b want 0000", {ready, busy, done, err});
      end
      n_vec++;
      if ({beat_cnt, err_cnt, first_err_idx, first_err_data} !== 128'd0) begin
         n_err++; $display("FAIL midrst_counters got %h/%h/%h/%h want 0", beat_cnt, err_cnt,
                           first_err_idx, first_err_data);
      end
      for (int i = 0; i < 4; i++) seq[i] = i;
      run_stream(4, 4, 1'b0, 1'b0, cyc, rl, cb, to, fb, fr);
      n_vec++;
      if (done !== 1'b1 || beat_cnt !== 32'd4 || err_cnt !== 32'd0) begin
         n_err++; $display("FAIL midrst_rerun got done=%b beats=%0d err_cnt=%0d want 1 4 0",
                           done, beat_cnt, err_cnt);
      end
   endtask

   // Ready pattern against an independent LFSR model, from a fresh reset
   task automatic test_lfsr();
      logic [15:0] model;
      int          guard;
      int          cnt;
      bit          acc;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      target = 32'd40; stall_en = 1'b1; valid = 1'b1; data = 32'd0; start = 1'b1;
      tick();
      start = 1'b0;
      model = 16'hACE1; guard = 0; cnt = 0;
      while (busy && guard < 400) begin
         n_vec++;
         if (ready !== model[0]) begin
            n_err++; $display("FAIL lfsr_ready cycle %0d got %b want %b", guard, ready, model[0]);
         end
         acc = ready && valid;
         tick();
         guard++;
         model = {1'b0, model[15:1]} ^ (model[0] ? 16'hB400 : 16'h0000);
         if (acc) begin
            cnt++;
            data = cnt;
         end
      end
      valid = 1'b0; stall_en = 1'b0;
      n_vec++;
      if (done !== 1'b1 || beat_cnt !== 32'd40 || err_cnt !== 32'd0 || guard >= 400) begin
         n_err++; $display("FAIL lfsr_run got done=%b beats=%0d err_cnt=%0d want 1 40 0",
                           done, beat_cnt, err_cnt);
      end
   endtask

   task automatic test_backpressure();
      int cyc, rl, cb;
      bit to, fb, fr;
      for (int i = 0; i < 1000; i++) seq[i] = i;
      run_stream(1000, 1000, 1'b1, 1'b1, cyc, rl, cb, to, fb, fr);
      stall_en = 1'b0;
      n_vec++;
      if (to !== 1'b0 || done !== 1'b1) begin
         n_err++; $display("FAIL bp_done got timeout=%b done=%b want 0 1", to, done);
      end
      n_vec++;
      if (err_cnt !== 32'd0 || beat_cnt !== 32'd1000) begin
         n_err++; $display("FAIL bp_result got err_cnt=%0d beats=%0d want 0 1000",
                           err_cnt, beat_cnt);
      end
      n_vec++;
      if (rl == 0) begin
         n_err++; $display("FAIL bp_ready_low got %0d low cycles want >0", rl);
      end
      n_vec++;
      if (cb !== 0) begin
         n_err++; $display("FAIL bp_count_track got %0d bad cycles want 0", cb);
      end
   endtask

   initial begin
      test_reset();
      test_target_zero();
      test_clean_run();
      test_single_error();
      test_second_error();
      test_restart();
      test_start_ignored();
      test_wrap();
      test_reset_mid_run();
      test_lfsr();
      test_backpressure();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/stream_seq_checker.md
# stream_seq_checker

Single-clock stream sink that consumes the destination side of the gray-code CDC FIFO (`dst_data_o`/`dst_valid_o`/`dst_ready_i`) and checks that the received words form a gapless incrementing sequence.
- It generates optional pseudo-random backpressure to exercise FIFO full/empty corners.
- It counts accepted beats and errors, and captures the first mismatch.
- It is synthesizable, so the same checking runs in FPGA bring-up and in simulation benches.

## Interface
Parameters:
- `DATA_WIDTH`, 32, width of checked word
- `CNT_WIDTH`, 32, width of beat/error counters and target
- `START_VALUE`, 0, first expected word after start
- `LFSR_SEED`, 16'hACE1, backpressure LFSR reset value (must be nonzero)

Ports:
- `clk_i` in 1: clock
- `rst_i` in 1: reset, synchronous, active-high
- `start_i` in 1: begin a run; honoured in IDLE or DONE only
- `target_i` in CNT_WIDTH: beats per run; sampled on accepted start
- `stall_en_i` in 1: enable random backpressure
- `data_i` in DATA_WIDTH: stream data
- `valid_i` in 1: stream valid
- `ready_o` out 1: stream ready
- `busy_o` out 1: state == RUN
- `done_o` out 1: state == DONE
- `beat_cnt_o` out CNT_WIDTH: accepted beats this run
- `err_cnt_o` out CNT_WIDTH: mismatching beats this run
- `err_o` out 1: sticky, at least one mismatch this run
- `first_err_idx_o` out CNT_WIDTH: beat index of first mismatch
- `first_err_data_o` out DATA_WIDTH: data of first mismatch

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE/DONE with `start_i` high: latch `target_i` and set expected = START_VALUE. Clear the beat counter, error counter, `err_o`, and first-error captures. Go to RUN, or straight to DONE if `target_i == 0`.
  - `start_i` is ignored in RUN.
- `ready_o = (state == RUN) && (!stall_en_i || lfsr[0])`.
  - Purely from registered state and `stall_en_i`; never depends on `valid_i`.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11. Advances every cycle in RUN regardless of handshake; holds otherwise.
- Handshake: a beat is accepted when `valid_i && ready_o` at a rising edge. Data is ignored when the beat is not accepted.
- On each accepted beat:
  - Compare `data_i` with expected.
  - Expected increments by 1, wrapping modulo 2^DATA_WIDTH. It is index-based: no resync to received data after an error.
  - `beat_cnt` increments.
  - On mismatch: `err_cnt` increments. If `err_o` was low, capture `first_err_idx = beat_cnt` (pre-increment value) and `first_err_data = data_i`, then set `err_o`.
- Counters saturate at all-ones and never wrap.
- Run end: when an accepted beat makes `beat_cnt + 1 == target`, go to DONE at that edge.
- DONE holds all results and keeps `ready_o` low until the next start or reset.

## Timing
- Reset values (all outputs):
  - `ready_o`, `busy_o`, `done_o`, `err_o` = 0
  - all counters and captures = 0
  - state IDLE, LFSR = LFSR_SEED, expected = START_VALUE
- Start accepted at edge N: `busy_o` and (unless stalled) `ready_o` are high in cycle N+1. The first beat can be accepted at edge N+1.
- Counter/error outputs update in the cycle after the accepting edge; comparison latency is 1 cycle.
- Last beat accepted at edge M: `done_o` = 1 and `ready_o` = 0 from cycle M+1, and `beat_cnt_o == target` in the same cycle.
- Throughput: 1 beat/cycle with `stall_en_i` = 0.
- `stall_en_i` may toggle at any time; it takes effect combinationally on `ready_o` in that cycle.
- Reset mid-run aborts immediately. All state returns to reset values at that edge; in-flight data is dropped.

## Test plan
- Clean run:
  - Stimulus: `target_i`=16, `stall_en_i`=0, source drives 0..15 with `valid_i` held high.
  - Required: `done_o` 17 cycles after start, `beat_cnt_o`=16, `err_cnt_o`=0, `err_o`=0.
- Single error:
  - Stimulus: sequence 0,1,2,7,4,5, `target_i`=6.
  - Required: `err_cnt_o`=1, `first_err_idx_o`=3, `first_err_data_o`=7, `beat_cnt_o`=6.
  - Also: a later second mismatch (value 9 at index 5) gives `err_cnt_o`=2 with the first-error captures unchanged.
- Random backpressure through the CDC FIFO:
  - Stimulus: `stall_en_i`=1, `target_i`=1000, source is `cdc_fifo_gray` (LOG_DEPTH=3) with an independent src clock writing 0..999.
  - Required: `err_cnt_o`=0, `done_o`=1.
  - Also: `ready_o` is low on at least one cycle, and no beat is counted while `ready_o`=0.
- Boundaries:
  - `target_i`=0 start → DONE next cycle, `ready_o` never high.
  - START_VALUE=2^32-2 with 4 beats (…FE, …FF, 0, 1) → `err_cnt_o`=0 (expected wraps).
  - `start_i` pulsed during RUN → ignored.
- Reset mid-run:
  - Stimulus: assert `rst_i` after 5 of 10 beats.
  - Required: next cycle all outputs are zero and state is IDLE. A new start then runs cleanly from START_VALUE.
- Restart from DONE:
  - Stimulus: start again after an erroring run.
  - Required: `err_o`, `err_cnt_o`, and the first-error captures clear in the cycle after start, and expected restarts at START_VALUE.
